// File: rtl/readout_rx_count_decision.sv
// Counts |1>-classified and total valid samples over a readout window and thresholds the |1> count.
// Decision pulses one cycle after finish_count_in; no backpressure, a sample is taken every valid cycle.
module readout_rx_count_decision #(
  parameter int COUNT_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   threshold_wr_en,
  input  logic [COUNT_WIDTH-1:0] threshold_wr_data,
  input  logic                   start_count_in,
  input  logic                   finish_count_in,
  input  logic                   valid_in,
  input  logic                   count_condition_in,
  output logic                   state_valid_out,
  output logic                   state_out,
  output logic [COUNT_WIDTH-1:0] one_count_out,
  output logic [COUNT_WIDTH-1:0] sample_count_out,
  output logic                   busy_out
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  state_e                 state_q,     state_d;
  logic [COUNT_WIDTH-1:0] thr_q,       thr_d;
  logic [COUNT_WIDTH-1:0] act_thr_q,   act_thr_d;
  logic [COUNT_WIDTH-1:0] one_cnt_q,   one_cnt_d;
  logic [COUNT_WIDTH-1:0] smp_cnt_q,   smp_cnt_d;
  logic                   state_vld_q, state_vld_d;
  logic                   state_bit_q, state_bit_d;
  logic [COUNT_WIDTH-1:0] one_out_q,   one_out_d;
  logic [COUNT_WIDTH-1:0] smp_out_q,   smp_out_d;
  logic                   busy_q,      busy_d;

  // Running totals including this cycle's sample, saturating at all-ones.
  logic [COUNT_WIDTH-1:0] one_fin;
  logic [COUNT_WIDTH-1:0] smp_fin;

  always_comb begin
    one_fin = one_cnt_q;
    smp_fin = smp_cnt_q;
    if (valid_in && (smp_cnt_q != CNT_MAX)) begin
      smp_fin = smp_cnt_q + CNT_ONE;
    end
    if (valid_in && count_condition_in && (one_cnt_q != CNT_MAX)) begin
      one_fin = one_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d     = state_q;
    thr_d       = threshold_wr_en ? threshold_wr_data : thr_q;
    act_thr_d   = act_thr_q;
    one_cnt_d   = one_cnt_q;
    smp_cnt_d   = smp_cnt_q;
    state_vld_d = 1'b0;
    state_bit_d = state_bit_q;
    one_out_d   = one_out_q;
    smp_out_d   = smp_out_q;

    if (state_q == IDLE) begin
      if (start_count_in) begin
        one_cnt_d = '0;
        smp_cnt_d = '0;
        act_thr_d = thr_d;
        state_d   = COUNT;
      end
    end else begin
      one_cnt_d = one_fin;
      smp_cnt_d = smp_fin;
      if (finish_count_in) begin
        state_vld_d = 1'b1;
        state_bit_d = (one_fin > act_thr_q);
        one_out_d   = one_fin;
        smp_out_d   = smp_fin;
        state_d     = IDLE;
      end
      // A start here either chains the next window or aborts the current one.
      if (start_count_in) begin
        one_cnt_d = '0;
        smp_cnt_d = '0;
        act_thr_d = thr_d;
        state_d   = COUNT;
      end
    end

    busy_d = (state_d == COUNT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      thr_q       <= '0;
      act_thr_q   <= '0;
      one_cnt_q   <= '0;
      smp_cnt_q   <= '0;
      state_vld_q <= 1'b0;
      state_bit_q <= 1'b0;
      one_out_q   <= '0;
      smp_out_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      thr_q       <= thr_d;
      act_thr_q   <= act_thr_d;
      one_cnt_q   <= one_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
      state_vld_q <= state_vld_d;
      state_bit_q <= state_bit_d;
      one_out_q   <= one_out_d;
      smp_out_q   <= smp_out_d;
      busy_q      <= busy_d;
    end
  end

  assign state_valid_out  = state_vld_q;
  assign state_out        = state_bit_q;
  assign one_count_out    = one_out_q;
  assign sample_count_out = smp_out_q;
  assign busy_out         = busy_q;

endmodule

// File: tb/tb_readout_rx_count_decision.sv
// Bench for readout_rx_count_decision: a default-width and a 4-bit instance share all stimulus,
// and each decision pulse is checked against a queue of expectations pushed when finish is driven.
module tb_readout_rx_count_decision;

  typedef struct {
    logic       st;
    logic [9:0] one;
    logic [9:0] smp;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       threshold_wr_en, start_count_in, finish_count_in, valid_in, count_condition_in;
  logic [9:0] threshold_wr_data_w;
  logic [3:0] threshold_wr_data_n;

  logic       sv_w, so_w, busy_w;
  logic [9:0] oc_w, sc_w;
  logic       sv_n, so_n, busy_n;
  logic [3:0] oc_n, sc_n;

  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;
  exp_t q_w[$];
  exp_t q_n[$];
  exp_t last_w, last_n, ew, en;

  // Reference model state, advanced as each stimulus cycle is driven.
  bit         in_count = 0;
  int         win_one  = 0;
  int         win_smp  = 0;
  logic [9:0] thr_m    = '0;
  logic [9:0] act_thr  = '0;

  readout_rx_count_decision u_dut_w (
    .clk                (clk),
    .rst                (rst),
    .threshold_wr_en    (threshold_wr_en),
    .threshold_wr_data  (threshold_wr_data_w),
    .start_count_in     (start_count_in),
    .finish_count_in    (finish_count_in),
    .valid_in           (valid_in),
    .count_condition_in (count_condition_in),
    .state_valid_out    (sv_w),
    .state_out          (so_w),
    .one_count_out      (oc_w),
    .sample_count_out   (sc_w),
    .busy_out           (busy_w)
  );

  readout_rx_count_decision #(.COUNT_WIDTH(4)) u_dut_n (
    .clk                (clk),
    .rst                (rst),
    .threshold_wr_en    (threshold_wr_en),
    .threshold_wr_data  (threshold_wr_data_n),
    .start_count_in     (start_count_in),
    .finish_count_in    (finish_count_in),
    .valid_in           (valid_in),
    .count_condition_in (count_condition_in),
    .state_valid_out    (sv_n),
    .state_out          (so_n),
    .one_count_out      (oc_n),
    .sample_count_out   (sc_n),
    .busy_out           (busy_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] sat(input int v, input int mx);
    return 10'((v > mx) ? mx : v);
  endfunction

  // Wide-instance monitor: pulses pop the scoreboard, other cycles must hold the last decision.
  always @(negedge clk) begin
    if (!rst) begin
      last_w = '{1'b0, 10'd0, 10'd0, 0};
    end else if (sv_w) begin
      check("pulse_expected_w", q_w.size(), (q_w.size() != 0) ? q_w.size() : 1);
      if (q_w.size() != 0) begin
        ew = q_w.pop_front();
        check("latency_w", ncyc, ew.due);
        check("state_w", so_w, ew.st);
        check("one_w", oc_w, ew.one);
        check("smp_w", sc_w, ew.smp);
        last_w = ew;
      end
    end else begin
      check("hold_state_w", so_w, last_w.st);
      check("hold_one_w", oc_w, last_w.one);
      check("hold_smp_w", sc_w, last_w.smp);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      last_n = '{1'b0, 10'd0, 10'd0, 0};
    end else if (sv_n) begin
      check("pulse_expected_n", q_n.size(), (q_n.size() != 0) ? q_n.size() : 1);
      if (q_n.size() != 0) begin
        en = q_n.pop_front();
        check("latency_n", ncyc, en.due);
        check("state_n", so_n, en.st);
        check("one_n", oc_n, en.one);
        check("smp_n", sc_n, en.smp);
        last_n = en;
      end
    end else begin
      check("hold_state_n", so_n, last_n.st);
      check("hold_one_n", oc_n, last_n.one);
      check("hold_smp_n", sc_n, last_n.smp);
    end
  end

  task automatic step(input logic st, input logic fin, input logic vld, input logic cond,
                      input logic we, input logic [9:0] wd);
    logic [9:0] thr_new;
    exp_t       e;
    @(negedge clk);
    check("busy_w", busy_w, in_count);
    check("busy_n", busy_n, in_count);
    start_count_in      = st;
    finish_count_in     = fin;
    valid_in            = vld;
    count_condition_in  = cond;
    threshold_wr_en     = we;
    threshold_wr_data_w = wd;
    threshold_wr_data_n = wd[3:0];
    thr_new = we ? wd : thr_m;
    if (in_count) begin
      if (vld) begin
        win_smp++;
        if (cond) win_one++;
      end
      if (fin) begin
        e.one = sat(win_one, 1023);
        e.smp = sat(win_smp, 1023);
        e.st  = (e.one > act_thr);
        e.due = ncyc + 1;
        q_w.push_back(e);
        e.one = sat(win_one, 15);
        e.smp = sat(win_smp, 15);
        e.st  = (e.one > {6'd0, act_thr[3:0]});
        q_n.push_back(e);
        in_count = 0;
      end
    end
    if (st) begin
      win_one  = 0;
      win_smp  = 0;
      act_thr  = thr_new;
      in_count = 1;
    end
    thr_m = thr_new;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 10'd0);
  endtask

  // Drives n valid samples (cond from pattern LSB first); finish/start options on the last one.
  task automatic samples(input logic [31:0] pattern, input int n, input logic fin_last,
                         input logic st_last);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) step(st_last, fin_last, 1, pattern[i], 0, 10'd0);
      else            step(0, 0, 1, pattern[i], 0, 10'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    threshold_wr_en = 0; threshold_wr_data_w = '0; threshold_wr_data_n = '0;
    start_count_in = 0; finish_count_in = 0; valid_in = 0; count_condition_in = 0;
    #1;
    check("rst_valid_w", sv_w, 0);  check("rst_state_w", so_w, 0);
    check("rst_one_w", oc_w, 0);    check("rst_smp_w", sc_w, 0);
    check("rst_busy_w", busy_w, 0); check("rst_valid_n", sv_n, 0);
    check("rst_one_n", oc_n, 0);    check("rst_busy_n", busy_n, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Threshold 3, pattern 1,1,0,1,1,0,0,0: 4 ones out of 8 -> |1>.
    step(0, 0, 0, 0, 1, 10'd3);
    step(1, 0, 0, 0, 0, 10'd0);
    samples(32'b0001_1011, 8, 1, 0);
    idle(2);

    // Threshold 4, same pattern: 4 is not greater than 4 -> |0>.
    step(0, 0, 0, 0, 1, 10'd4);
    step(1, 0, 0, 0, 0, 10'd0);
    samples(32'b0001_1011, 8, 1, 0);
    idle(2);

    // Threshold 10, 20 ones: the 4-bit instance saturates at 15.
    step(0, 0, 0, 0, 1, 10'd10);
    step(1, 0, 0, 0, 0, 10'd0);
    samples(32'hFFFFF, 20, 1, 0);
    idle(2);

    // Back-to-back windows: A = 5/5, B starts on A's finish with 1 one out of 4; threshold 2.
    step(0, 0, 0, 0, 1, 10'd2);
    step(1, 0, 0, 0, 0, 10'd0);
    samples(32'b1_1111, 5, 1, 1);
    samples(32'b0001, 4, 1, 0);
    idle(2);

    // Threshold 1 written on the start cycle, 9 written mid-window; next window uses 9.
    step(1, 0, 0, 0, 1, 10'd1);
    step(0, 0, 1, 1, 0, 10'd0);
    step(0, 0, 1, 1, 1, 10'd9);
    step(0, 1, 1, 1, 0, 10'd0);
    idle(1);
    step(1, 0, 0, 0, 0, 10'd0);
    samples(32'hFF, 8, 1, 0);
    idle(2);

    // IDLE: valid samples and finish ignored, start+finish acts as start; then a restart.
    step(0, 1, 1, 1, 0, 10'd0);
    step(0, 0, 1, 1, 0, 10'd0);
    step(1, 1, 0, 0, 0, 10'd0);
    samples(32'b111, 3, 0, 0);
    step(1, 0, 0, 0, 1, 10'd1);
    samples(32'b11, 2, 1, 0);
    idle(2);

    // Reset mid-window: outputs clear at once and the window never produces a decision.
    step(1, 0, 0, 0, 0, 10'd0);
    samples(32'b111, 3, 0, 0);
    step(0, 0, 0, 0, 0, 10'd0);
    #2;
    rst = 1'b0;
    in_count = 0; win_one = 0; win_smp = 0; thr_m = '0; act_thr = '0;
    #1;
    check("arst_state_w", so_w, 0); check("arst_one_w", oc_w, 0);
    check("arst_smp_w", sc_w, 0);   check("arst_busy_w", busy_w, 0);
    check("arst_one_n", oc_n, 0);   check("arst_busy_n", busy_n, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step(0, 1, 0, 0, 0, 10'd0);
    idle(3);
    check("post_rst_one_w", oc_w, 0);
    check("post_rst_smp_w", sc_w, 0);

    check("pending_w", q_w.size(), 0);
    check("pending_n", q_n.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
